// File: rtl/sb_rx_deframer.sv
// Sideband UART-style receiver with DLE/STX/ETX transaction deframing.
// Optional saturating error counter on err_cnt when SB_RX_ERR_CNT_EN is defined.
module sb_rx_deframer (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       sbrx,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_sop,
    output logic       rx_type,
    output logic       rx_done,
    output logic [6:0] rx_len,
    output logic       rx_err,
    output logic [1:0] rx_err_code
`ifdef SB_RX_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam logic [7:0] DLE     = 8'hFE;
    localparam logic [7:0] STX_CMD = 8'h05;
    localparam logic [7:0] STX_RSP = 8'h04;
    localparam logic [7:0] ETX     = 8'h40;

    localparam logic [6:0] MAX_LEN = 7'd64;

    localparam logic [1:0] E_STOP = 2'd1;
    localparam logic [1:0] E_ESC  = 2'd2;
    localparam logic [1:0] E_LEN  = 2'd3;

    typedef enum logic [1:0] {
        B_IDLE,
        B_DATA,
        B_STOP,
        B_BREAK
    } bstate_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_DLE,
        T_PAY,
        T_PAY_DLE
    } tstate_t;

    bstate_t    bst_q;
    logic [2:0] bcnt_q;
    logic [7:0] shreg_q;

    tstate_t    tst_q;
    logic [6:0] cnt_q;
    logic [6:0] cnt_d;
    logic       full;

    logic [7:0] data_q;
    logic       valid_q;
    logic       sop_q;
    logic       type_q;
    logic       done_q;
    logic [6:0] len_q;
    logic       err_q;
    logic [1:0] code_q;

    logic       byte_good;
    logic       byte_bad;
    logic       in_pay;

    // A byte is decided on the edge that samples its stop bit.
    assign byte_good = rx_en && (bst_q == B_STOP) && sbrx;
    assign byte_bad  = rx_en && (bst_q == B_STOP) && !sbrx;

    assign in_pay = (tst_q == T_PAY) || (tst_q == T_PAY_DLE);
    assign cnt_d  = cnt_q + 7'd1;
    assign full   = (cnt_q == MAX_LEN);

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            bst_q   <= B_IDLE;
            bcnt_q  <= 3'd0;
            shreg_q <= 8'h00;
        end else if (!rx_en) begin
            bst_q  <= B_IDLE;
            bcnt_q <= 3'd0;
        end else begin
            unique case (bst_q)
                B_IDLE: begin
                    if (!sbrx) begin
                        bst_q  <= B_DATA;
                        bcnt_q <= 3'd0;
                    end
                end
                B_DATA: begin
                    shreg_q <= {sbrx, shreg_q[7:1]};
                    bcnt_q  <= bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        bst_q <= B_STOP;
                    end
                end
                B_STOP: begin
                    bst_q <= sbrx ? B_IDLE : B_BREAK;
                end
                B_BREAK: begin
                    if (sbrx) begin
                        bst_q <= B_IDLE;
                    end
                end
                default: bst_q <= B_IDLE;
            endcase
        end
    end

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            tst_q   <= T_IDLE;
            cnt_q   <= 7'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            type_q  <= 1'b0;
            done_q  <= 1'b0;
            len_q   <= 7'd0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (!rx_en) begin
                tst_q <= T_IDLE;
            end else if (byte_bad) begin
                if (in_pay) begin
                    err_q  <= 1'b1;
                    code_q <= E_STOP;
                end
                tst_q <= T_IDLE;
            end else if (byte_good) begin
                unique case (tst_q)
                    T_IDLE: begin
                        if (shreg_q == DLE) begin
                            tst_q <= T_DLE;
                        end
                    end
                    T_DLE: begin
                        if (shreg_q == STX_CMD || shreg_q == STX_RSP) begin
                            tst_q  <= T_PAY;
                            type_q <= (shreg_q == STX_RSP);
                            cnt_q  <= 7'd0;
                        end else if (shreg_q != DLE) begin
                            tst_q <= T_IDLE;
                        end
                    end
                    T_PAY: begin
                        if (shreg_q == DLE) begin
                            tst_q <= T_PAY_DLE;
                        end else if (full) begin
                            err_q  <= 1'b1;
                            code_q <= E_LEN;
                            tst_q  <= T_IDLE;
                        end else begin
                            data_q  <= shreg_q;
                            valid_q <= 1'b1;
                            sop_q   <= (cnt_q == 7'd0);
                            cnt_q   <= cnt_d;
                        end
                    end
                    T_PAY_DLE: begin
                        if (shreg_q == DLE) begin
                            if (full) begin
                                err_q  <= 1'b1;
                                code_q <= E_LEN;
                                tst_q  <= T_IDLE;
                            end else begin
                                data_q  <= DLE;
                                valid_q <= 1'b1;
                                sop_q   <= (cnt_q == 7'd0);
                                cnt_q   <= cnt_d;
                                tst_q   <= T_PAY;
                            end
                        end else if (shreg_q == ETX) begin
                            if (cnt_q == 7'd0) begin
                                err_q  <= 1'b1;
                                code_q <= E_LEN;
                            end else begin
                                done_q <= 1'b1;
                                len_q  <= cnt_q;
                            end
                            tst_q <= T_IDLE;
                        end else begin
                            err_q  <= 1'b1;
                            code_q <= E_ESC;
                            tst_q  <= T_IDLE;
                        end
                    end
                    default: tst_q <= T_IDLE;
                endcase
            end
        end
    end

`ifdef SB_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= 8'd0;
        end else if (err_q && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign rx_data       = data_q;
    assign rx_data_valid = valid_q;
    assign rx_sop        = sop_q;
    assign rx_type       = type_q;
    assign rx_done       = done_q;
    assign rx_len        = len_q;
    assign rx_err        = err_q;
    assign rx_err_code   = code_q;

endmodule

// File: doc/sb_rx_deframer.md
SB_RX_DEFRAMER -- requirements
Module: sb_rx_deframer

Interface
REQ-001 SHALL use a single clock and an asynchronous, active-low reset.
REQ-002 Port: sb_clk  in  1  sideband clock, one bit period per cycle; all logic on rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-low reset.
REQ-004 Port: sbrx  in  1  serial sideband line; idle high.
REQ-005 Port: rx_en  in  1  deframer enable; when low, line is ignored and both FSMs held in idle.
REQ-006 Port: rx_data  out  8  de-stuffed payload byte.
REQ-007 Port: rx_data_valid  out  1  one-cycle strobe qualifying rx_data.
REQ-008 Port: rx_sop  out  1  high with rx_data_valid on the first payload byte of a transaction.
REQ-009 Port: rx_type  out  1  0 = command (STX_CMD), 1 = response (STX_RSP); held from STX until next STX.
REQ-010 Port: rx_done  out  1  one-cycle strobe on valid transaction end.
REQ-011 Port: rx_len  out  7  payload byte count, valid with rx_done, range 1..64.
REQ-012 Port: rx_err  out  1  one-cycle strobe on transaction abort.
REQ-013 Port: rx_err_code  out  2  valid with rx_err: 1 stop-bit error, 2 bad escape, 3 length error.

Function
REQ-014 Symbols: DLE = 8'hFE, STX_CMD = 8'h05, STX_RSP = 8'h04, ETX = 8'h40.
REQ-015 Byte FSM states: B_IDLE, B_DATA, B_STOP, B_BREAK.
REQ-016 B_IDLE: sbrx==0 sampled -> B_DATA, bit counter cleared.
REQ-017 B_DATA: sample 8 bits LSB first, one per cycle; after 8th -> B_STOP.
REQ-018 B_STOP: sbrx==1 -> byte good, B_IDLE; sbrx==0 -> stop-bit error, B_BREAK.
REQ-019 B_BREAK: remain until sbrx==1 sampled, then B_IDLE.
REQ-020 Back-to-back bytes: start bit accepted in the cycle immediately after the stop bit.
REQ-021 Transaction FSM states: T_IDLE, T_DLE, T_PAY, T_PAY_DLE; advances only on good bytes.
REQ-022 T_IDLE: DLE -> T_DLE; any other byte discarded.
REQ-023 T_DLE: STX_CMD/STX_RSP -> T_PAY, latch rx_type, clear count; DLE -> stay; other -> T_IDLE, no error.
REQ-024 T_PAY: DLE -> T_PAY_DLE; other byte -> emitted as payload.
REQ-025 T_PAY_DLE: DLE -> emit 8'hFE, T_PAY; ETX -> end; other -> rx_err code 2, T_IDLE.
REQ-026 Latency: rx_data_valid/rx_done/rx_err assert the cycle after the stop bit of the deciding byte is sampled.
REQ-027 Payload count is 7 bits; 65th payload byte -> rx_err code 3, T_IDLE, byte not emitted.
REQ-028 ETX with count 0 -> rx_err code 3, no rx_done.
REQ-029 Stop-bit error while in T_PAY or T_PAY_DLE -> rx_err code 1, T_IDLE; in T_IDLE/T_DLE -> silent, T_IDLE.
REQ-030 rx_en deasserted mid-transaction -> both FSMs to idle next cycle, no rx_err, no rx_done.
REQ-031 rx_data_valid, rx_done, rx_err mutually exclusive in any cycle.

Reset
REQ-032 On rst low: FSMs B_IDLE/T_IDLE; all outputs 0, counters 0, asynchronously.
REQ-033 Reset mid-byte or mid-transaction discards partial data with no strobes after release.

Configuration
REQ-034 Macro SB_RX_ERR_CNT_EN defined: adds output err_cnt [7:0], saturating count of rx_err strobes, reset 0, saturates at 255.
REQ-035 Macro SB_RX_ERR_CNT_EN undefined: err_cnt port and counter absent; all other behaviour identical.

Verification
REQ-036 Serialize FE 05 11 22 DLE ETX -> rx_data 11 (sop, type 0) then 22; rx_done len 2.
REQ-037 Serialize FE 04 FE FE 33 FE 40 -> rx_data FE (sop, type 1), 33; rx_done len 2.
REQ-038 FE 05 AA, then byte with stop bit 0 -> rx_data AA, then rx_err code 1; line high, next FE 05 01 FE 40 -> rx_done len 1.
REQ-039 FE 05 followed by 65 payload bytes of 8'h00 -> 64 rx_data_valid, rx_err code 3, no rx_done.
REQ-040 FE 05 10 FE 07 -> rx_data 10, rx_err code 2; FE 05 FE 40 -> rx_err code 3.
REQ-041 rst low during 3rd data bit of a payload byte, release, send FE 05 55 FE 40 -> single rx_data 55 with sop, rx_done len 1; with SB_RX_ERR_CNT_EN, err_cnt 0.
